// File: rtl/pwm_level_decoder_pkg.sv
// Constants shared by the PWM generator and the PWM level decoder so both ends agree on period.
package pwm_level_decoder_pkg;

  localparam int PWM_CNT_W  = 16;
  localparam int PWM_PERIOD = 2 ** PWM_CNT_W;

  // True when a measured period lies within +/-tol clocks of the nominal period.
  function automatic logic period_in_tol(input int unsigned period,
                                         input int unsigned target,
                                         input int unsigned tol);
    return ((period + tol) >= target) && (period <= (target + tol));
  endfunction

endpackage

// File: rtl/pwm_level_decoder_if.sv
// PWM stream in, recovered level and status out; master drives the stream, slave decodes it.
interface pwm_level_decoder_if #(
  parameter int CNT_W = pwm_level_decoder_pkg::PWM_CNT_W
);

  logic             pwm_in;
  logic [CNT_W-1:0] level;
  logic             level_valid;
  logic             locked;
  logic             stuck;

  modport master (output pwm_in, input level, level_valid, locked, stuck);
  modport slave  (input pwm_in, output level, level_valid, locked, stuck);

endinterface

// File: rtl/pwm_in_sync.sv
// Brings the asynchronous PWM stream into the CLK100MHZ domain and flags its rising edges.
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK100MHZ,
  input  logic ck_rst,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      sync_q <= '0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;

endmodule

// File: rtl/pwm_level_decoder.sv
// Recovers the level of a cnt-compare PWM stream over fixed one-period windows, with period lock and stuck detection.
module pwm_level_decoder
  import pwm_level_decoder_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 4
) (
  input logic                CLK100MHZ,
  input logic                ck_rst,
  pwm_level_decoder_if.slave bus
);

  localparam int                PER_W       = CNT_W + 2;
  localparam int                GOOD_W      = $clog2(LOCK_COUNT + 1);
  localparam int unsigned       PERIOD      = 2 ** CNT_W;
  localparam logic [PER_W:0]    STUCK_LIMIT = (PER_W + 1)'(PERIOD + LOCK_TOL);
  localparam logic [GOOD_W-1:0] GOOD_MAX    = GOOD_W'(LOCK_COUNT);

  logic              pwm_s;
  logic              rise;
  logic [CNT_W-1:0]  win_cnt;
  logic              win_end;
  logic [CNT_W:0]    acc;
  logic [CNT_W:0]    sum;
  logic              primed;
  logic [PER_W-1:0]  per_cnt;
  logic [PER_W:0]    per_inc;
  logic              over;
  logic              in_tol;
  logic              seen_rise;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_nxt;

  pwm_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK100MHZ (CLK100MHZ),
    .ck_rst    (ck_rst),
    .pwm_in    (bus.pwm_in),
    .pwm_s     (pwm_s),
    .rise      (rise)
  );

  assign win_end = (win_cnt == '1);
  assign sum     = acc + (CNT_W + 1)'(pwm_s);
  assign per_inc = {1'b0, per_cnt} + 1'b1;
  assign over    = (per_inc > STUCK_LIMIT);
  assign in_tol  = period_in_tol(32'(per_inc), PERIOD, LOCK_TOL);

  // The first rise only starts a measurement; an overlong gap breaks lock without waiting for a rise.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    good_nxt = good_cnt;
    if (rise) begin
      if (seen_rise) begin
        if (!in_tol)                good_nxt = '0;
        else if (good_cnt != GOOD_MAX) good_nxt = good_cnt + 1'b1;
      end
    end else if (over) begin
      good_nxt = '0;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      win_cnt         <= '0;
      acc             <= '0;
      primed          <= 1'b0;
      per_cnt         <= '0;
      seen_rise       <= 1'b0;
      good_cnt        <= '0;
      bus.level       <= '0;
      bus.level_valid <= 1'b0;
      bus.locked      <= 1'b0;
      bus.stuck       <= 1'b0;
    end else begin
      win_cnt         <= win_cnt + 1'b1;
      bus.level_valid <= 1'b0;

      // The first window after reset only covers synchronizer warm-up and is dropped.
      if (win_end) begin
        acc    <= '0;
        primed <= 1'b1;
        if (primed) begin
          bus.level       <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
          bus.level_valid <= 1'b1;
        end
      end else begin
        acc <= sum;
      end

      if (rise) begin
        per_cnt   <= '0;
        seen_rise <= 1'b1;
      end else if (!(&per_cnt)) begin
        per_cnt <= per_inc[PER_W-1:0];
      end

      good_cnt   <= good_nxt;
      bus.locked <= (good_nxt == GOOD_MAX);
      bus.stuck  <= over & ~rise;
    end
  end

endmodule

// File: tb/tb_pwm_level_decoder.sv
// Directed bench for pwm_level_decoder with a 6-bit counter (64-clock period) so every scenario stays short.
module tb_pwm_level_decoder;

  localparam int CNT_W = 6;

  logic clk;
  logic ck_rst;

  int   gen_level;
  int   gen_period;
  int   gen_phase;
  logic gen_tie;
  int   n_rise;

  int   n_cmp;
  int   n_err;

  pwm_level_decoder_if #(.CNT_W(CNT_W)) bus ();

  pwm_level_decoder #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (2),
    .LOCK_TOL    (2),
    .LOCK_COUNT  (4)
  ) dut (
    .CLK100MHZ (clk),
    .ck_rst    (ck_rst),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus generator: cnt-compare PWM with its own period/phase, frozen at gen_phase while in reset.
  initial begin
    int   gen_cnt;
    logic prev;
    gen_cnt    = 0;
    bus.pwm_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      prev = bus.pwm_in;
      if (!ck_rst) begin
        gen_cnt = gen_phase;
        n_rise  = 0;
      end else begin
        gen_cnt = (gen_cnt + 1 >= gen_period) ? 0 : gen_cnt + 1;
      end
      bus.pwm_in = gen_tie || (gen_cnt < gen_level);
      if (ck_rst && !prev && bus.pwm_in) n_rise++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input string tag, input int lvl, input int per, input int phase);
    @(negedge clk);
    #2;
    ck_rst = 1'b0;
    #1;
    check({tag, "_rst_level"}, 32'(bus.level), 0);
    check({tag, "_rst_valid"}, 32'(bus.level_valid), 0);
    check({tag, "_rst_locked"}, 32'(bus.locked), 0);
    check({tag, "_rst_stuck"}, 32'(bus.stuck), 0);
    gen_level  = lvl;
    gen_period = per;
    gen_phase  = phase;
    gen_tie    = 1'b0;
    repeat (3) @(negedge clk);
    ck_rst = 1'b1;
  endtask

  task automatic wait_rises(input string tag, input int target);
    for (int i = 0; i < 600 && n_rise < target; i++) @(negedge clk);
    check({tag, "_rise_seen"}, 32'(n_rise >= target), 1);
  endtask

  task automatic wait_valid(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.level_valid;
    end
    check({tag, "_valid_seen"}, 32'(seen), 1);
  endtask

  initial begin
    int hits;
    int lvl;
    n_cmp      = 0;
    n_err      = 0;
    ck_rst     = 1'b1;
    gen_level  = 0;
    gen_period = 64;
    gen_phase  = 0;
    gen_tie    = 1'b0;

    // 1: half level with the generator phase offset (12345 mod 64 = 57).
    do_reset("t1", 32, 64, 57);
    wait_rises("t1_r4", 4);
    step(6);
    check("t1_unlocked_after_4", 32'(bus.locked), 0);
    wait_rises("t1_r5", 5);
    step(6);
    check("t1_locked_after_5", 32'(bus.locked), 1);
    check("t1_stuck", 32'(bus.stuck), 0);
    for (int k = 0; k < 3; k++) begin
      wait_valid("t1");
      check("t1_level", 32'(bus.level), 32);
    end

    // 2: constant low input.
    do_reset("t2", 0, 64, 0);
    step(66);
    check("t2_stuck_before_limit", 32'(bus.stuck), 0);
    step(1);
    check("t2_stuck_at_limit", 32'(bus.stuck), 1);
    wait_valid("t2");
    check("t2_level", 32'(bus.level), 0);
    check("t2_locked", 32'(bus.locked), 0);

    // 3: maximum level, then input tied high.
    do_reset("t3", 63, 64, 63);
    wait_rises("t3_r5", 5);
    step(6);
    check("t3_locked", 32'(bus.locked), 1);
    wait_valid("t3");
    check("t3_level_max", 32'(bus.level), 63);
    gen_tie = 1'b1;
    step(200);
    check("t3_tied_stuck", 32'(bus.stuck), 1);
    check("t3_tied_locked", 32'(bus.locked), 0);
    wait_valid("t3_tied_a");
    check("t3_tied_level_a", 32'(bus.level), 63);
    wait_valid("t3_tied_b");
    check("t3_tied_level_b", 32'(bus.level), 63);

    // 4: level change part-way through a window.
    do_reset("t4", 10, 64, 0);
    wait_valid("t4_old");
    check("t4_level_old", 32'(bus.level), 10);
    step(30);
    gen_level = 40;
    wait_valid("t4_mid");
    lvl = int'(bus.level);
    check("t4_level_between", 32'(lvl > 10 && lvl < 40), 1);
    wait_valid("t4_new_a");
    check("t4_level_new_a", 32'(bus.level), 40);
    wait_valid("t4_new_b");
    check("t4_level_new_b", 32'(bus.level), 40);

    // 5a: period 64+5 is outside tolerance, lock must never appear.
    do_reset("t5a", 32, 69, 40);
    hits = 0;
    for (int i = 0; i < 700 && n_rise < 8; i++) begin
      @(negedge clk);
      if (bus.locked) hits++;
    end
    check("t5a_rises", 32'(n_rise >= 8), 1);
    check("t5a_never_locked", 32'(hits), 0);

    // 5b: period 64+2 locks; one long period drops lock, four good periods restore it.
    do_reset("t5b", 32, 66, 40);
    wait_rises("t5b_r4", 4);
    step(6);
    check("t5b_unlocked_after_4", 32'(bus.locked), 0);
    wait_rises("t5b_r5", 5);
    step(6);
    check("t5b_locked_after_5", 32'(bus.locked), 1);
    wait_rises("t5b_r6", 6);
    gen_period = 80;
    wait_rises("t5b_r7", 7);
    gen_period = 66;
    step(6);
    check("t5b_lock_lost", 32'(bus.locked), 0);
    wait_rises("t5b_r10", 10);
    step(6);
    check("t5b_relock_3_good", 32'(bus.locked), 0);
    wait_rises("t5b_r11", 11);
    step(6);
    check("t5b_relock_4_good", 32'(bus.locked), 1);

    // 6: reset while locked clears outputs at once; first level_valid after exactly two windows.
    do_reset("t6", 32, 64, 57);
    step(127);
    check("t6_valid_early", 32'(bus.level_valid), 0);
    step(1);
    check("t6_valid_first", 32'(bus.level_valid), 1);
    check("t6_level_first", 32'(bus.level), 32);
    step(1);
    check("t6_valid_pulse_end", 32'(bus.level_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
